// File: rtl/gds_symbol_demod.sv
// gds_symbol_demod: recovers data bits from the gated GDS serial stream.
// Each window of BIT accepted samples is integrated (GDS ANDed with the
// QMOD gate) and sliced against THRESH; WAVE consecutive decisions are
// packed LSB-first into a word.
module gds_symbol_demod #(
    parameter int BIT    = 2498,
    parameter int WAVE   = 8,
    parameter int THRESH = 1249
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         sync,
    input  logic                         gds_in,
    input  logic                         qmod_in,
    output logic                         sym_bit,
    output logic                         sym_valid,
    output logic [WAVE-1:0]              word,
    output logic                         word_valid,
    output logic [$clog2(BIT+1)-1:0]     ones_cnt
);

    // Accumulator width holds 0..BIT, so a full window never overflows.
    localparam int CW = $clog2(BIT + 1);
    localparam int SW = (BIT > 1) ? $clog2(BIT) : 1;
    localparam int YW = (WAVE > 1) ? $clog2(WAVE) : 1;

    localparam logic [SW-1:0] LAST_SAMPLE = SW'(BIT - 1);
    localparam logic [SW-1:0] SAMPLE_ONE  = SW'(1);
    localparam logic [YW-1:0] LAST_SYM    = YW'(WAVE - 1);
    localparam logic [YW-1:0] SYM_ONE     = YW'(1);
    localparam logic [CW-1:0] THR         = CW'(THRESH);

    // With a one-sample window the sync sample would itself complete the
    // symbol, so it cannot be carried forward as sample 0 of a new one.
    localparam bit SYNC_KEEPS_SAMPLE = (BIT > 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [CW-1:0]     r_acc;
    logic [SW-1:0]     r_sample_idx;
    logic [YW-1:0]     r_sym_idx;
    logic [WAVE-1:0]   r_shift;

    logic              r_sym_bit;
    logic              r_sym_valid;
    logic [WAVE-1:0]   r_word;
    logic              r_word_valid;
    logic [CW-1:0]     r_ones_cnt;

    logic              w_gated;
    logic [CW-1:0]     w_total;
    logic              w_last_sample;
    logic              w_last_sym;
    logic              w_bit;
    logic              w_active;
    logic [WAVE-1:0]   w_shift_ins;

    assign w_gated       = gds_in & qmod_in;
    assign w_total       = r_acc + CW'(w_gated);
    assign w_last_sample = (r_sample_idx == LAST_SAMPLE);
    assign w_last_sym    = (r_sym_idx == LAST_SYM);
    assign w_bit         = (w_total >= THR);

    // Counting is live in ACCUM, and also on the IDLE cycle that triggers
    // the move into ACCUM, so that cycle's sample becomes sample 0.
    assign w_active = (r_state == S_ACCUM) || en || sync;

    // Word accumulator with the current decision dropped into slot sym_idx.
    genvar gi;
    generate
        for (gi = 0; gi < WAVE; gi = gi + 1) begin : g_insert
            assign w_shift_ins[gi] = (r_sym_idx == YW'(gi)) ? w_bit : r_shift[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave IDLE on the first strobe, then stay in ACCUM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (en || sync) w_state_next = S_ACCUM;
            S_ACCUM: w_state_next = S_ACCUM;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sample integration, symbol slicing and word assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_sample_idx <= '0;
            r_sym_idx    <= '0;
            r_shift      <= '0;
            r_sym_bit    <= 1'b0;
            r_sym_valid  <= 1'b0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_ones_cnt   <= '0;
        end else begin
            r_sym_valid  <= 1'b0;
            r_word_valid <= 1'b0;
            if (sync) begin
                // Realign: drop partial symbol and word, no pulses.
                r_sym_idx <= '0;
                r_shift   <= '0;
                if (en && SYNC_KEEPS_SAMPLE) begin
                    r_acc        <= CW'(w_gated);
                    r_sample_idx <= SAMPLE_ONE;
                end else begin
                    r_acc        <= '0;
                    r_sample_idx <= '0;
                end
            end else if (en && w_active) begin
                if (w_last_sample) begin
                    r_sym_bit    <= w_bit;
                    r_ones_cnt   <= w_total;
                    r_sym_valid  <= 1'b1;
                    r_acc        <= '0;
                    r_sample_idx <= '0;
                    if (w_last_sym) begin
                        r_word       <= w_shift_ins;
                        r_word_valid <= 1'b1;
                        r_shift      <= '0;
                        r_sym_idx    <= '0;
                    end else begin
                        r_shift   <= w_shift_ins;
                        r_sym_idx <= r_sym_idx + SYM_ONE;
                    end
                end else begin
                    r_acc        <= w_total;
                    r_sample_idx <= r_sample_idx + SAMPLE_ONE;
                end
            end
        end
    end

    assign sym_bit    = r_sym_bit;
    assign sym_valid  = r_sym_valid;
    assign word       = r_word;
    assign word_valid = r_word_valid;
    assign ones_cnt   = r_ones_cnt;

endmodule

// File: doc/gds_symbol_demod.md
# gds_symbol_demod

Downstream consumer of the GDS/QMOD waveform generator. It samples the serial GDS stream one bit per clock, gated by the QMOD envelope, and integrates each fixed-length symbol window. It slices each window to a recovered data bit and reassembles WAVE consecutive bits into a word. It closes the loop on the playback path so the transmitted bit sequence can be checked in simulation and on hardware.

## Interface
- BIT, default 2498: samples per symbol window; equals the generator's per-symbol table length.
- WAVE, default 8: symbols per word.
- THRESH, default 1249: minimum gated-ones count for a symbol to decide as 1. Range 1..BIT.
- clk  input  1  clock. Shared with the generator.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- en  input  1  sample-accept strobe; gds_in and qmod_in are consumed only when en=1.
- sync  input  1  realign pulse; the current cycle becomes sample 0 of symbol 0.
- gds_in  input  1  GDS serial sample.
- qmod_in  input  1  QMOD gate sample; a GDS sample counts only when qmod_in=1.
- sym_bit  output  1  most recent decided bit.
- sym_valid  output  1  one-cycle pulse: sym_bit updated.
- word  output  WAVE  most recent completed word. Symbol k goes to bit k (LSB first).
- word_valid  output  1  one-cycle pulse: word updated.
- ones_cnt  output  $clog2(BIT+1)  gated-ones total of the last decided symbol.

## Operation
- State machine:
  - IDLE: entered on reset. Moves to ACCUM on the first cycle with en=1 or sync=1.
  - ACCUM: all counting. There is no exit except reset.
- Counters:
  - sample_idx: 0..BIT-1.
  - sym_idx: 0..WAVE-1.
  - acc: $clog2(BIT+1) bits. Saturation cannot occur.
  - shift word accumulator: WAVE bits.
- Accepted sample (en=1):
  - acc += (gds_in & qmod_in).
  - sample_idx increments.
- At the accepted sample with sample_idx==BIT-1:
  - total = acc + current gated sample.
  - Decide bit = (total >= THRESH), unsigned compare.
  - Register sym_bit and ones_cnt=total.
  - Write the bit into accumulator position sym_idx.
  - Clear acc and sample_idx to 0.
  - Increment sym_idx.
- When sym_idx==WAVE-1 at a decision:
  - word <= accumulator with the new bit inserted.
  - word_valid pulses.
  - sym_idx wraps to 0.
  - Clear the accumulator.
- en=0: all counters and acc hold. The sample is ignored and no pulses are generated.
- sync=1:
  - Discard the partial symbol and partial word.
  - sample_idx=0, sym_idx=0.
  - If en=1 in the same cycle, that sample is accepted as sample 0 (acc = gated sample). Otherwise acc=0.
  - sync takes precedence over a decision falling in the same cycle; no sym_valid or word_valid is generated.
- Reset (rst_n=0 at a clk edge), also mid-symbol:
  - State returns to IDLE.
  - All counters clear to 0.
  - Outputs return to reset values.
  - The first post-reset accepted sample is sample 0.

## Timing
- Output reset values: sym_bit=0, sym_valid=0, word=0, word_valid=0, ones_cnt=0.
- sym_valid asserts the cycle after the clock edge that accepts sample BIT-1. It lasts exactly one cycle.
- word_valid asserts in the same cycle as the sym_valid of symbol WAVE-1.
- sym_bit, ones_cnt and word hold until the next respective update.
- Generator alignment: the generator registers its output, so the bench asserts en the cycle after the generator's first output is valid. With continuous en, sym_valid recurs every BIT cycles and word_valid every BIT*WAVE cycles.
- Minimum spacing: sym_valid pulses are at least BIT cycles apart (BIT≥1). With BIT=1, sym_valid may assert every cycle.

## Test plan
- Default params. Generator playing sequence 0x95, en continuous from its first valid output:
  - sym_bit order 1,0,1,0,1,0,0,1.
  - word_valid after 8*2498 accepted samples with word=8'h95.
- BIT=16, THRESH=8. gds_in=1, qmod_in=0 for all samples:
  - Every ones_cnt=0 and sym_bit=0.
  - word=8'h00.
- BIT=16, THRESH=8. Symbol with exactly 7 gated ones, then a symbol with exactly 8:
  - ones_cnt=7, sym_bit=0.
  - Then ones_cnt=8, sym_bit=1.
- BIT=16. en dropped for 5 cycles at sample 9:
  - sym_valid delayed by exactly 5 cycles.
  - ones_cnt unchanged versus the uninterrupted run.
- sync during symbol 3, sample 4; also sync coincident with sample BIT-1:
  - No pulse is emitted for the discarded partial symbol or word.
  - The next word_valid comes BIT*WAVE accepted samples after the sync.
- rst_n low for one cycle mid-symbol:
  - All outputs are 0 on the next cycle.
  - Decoding restarts and reproduces 8'h95 from a fresh generator start.
